// File: rtl/handshake_sync_rx_mc.sv
// Multi-channel receive side of a cross-domain req/ack handshake, clocked by sys_clk.
// Each channel synchronises req_async, raises one evt_valid per request, waits for the
// consumer, then returns a flopped acknowledge. MODE 0 = 4-phase level, MODE 1 = 2-phase toggle.
// Optional build macro HS_CNT_EN adds a saturating per-channel accepted-event counter.
module handshake_sync_rx_mc #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MODE        = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [CH-1:0]       req_async,
  output logic [CH-1:0]       ack_async,
  output logic [CH-1:0]       evt_valid,
  input  logic [CH-1:0]       evt_ready,
  output logic [CH-1:0]       busy,
  output logic [CH-1:0]       err,
  input  logic [CH-1:0]       err_clr,
  input  logic [CH-1:0]       cnt_clr,
  output logic [CH*CNT_W-1:0] evt_cnt
);

  // A single-flop synchroniser is never safe, so shallower settings are widened to two.
  localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {StIdle, StPend, StAck} state_e;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [Stages-1:0] sync_q;
    logic              req_s;
    logic              req_p_q;
    state_e            state_q, state_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              skip_q, skip_d;
    logic              det, accept, fall, err_set;
    logic              valid_c, busy_c;

    assign req_s = sync_q[Stages-1];

    // Synchroniser chain plus one extra flop for edge detection
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        sync_q  <= '0;
        req_p_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[Stages-2:0], req_async[i]};
        req_p_q <= req_s;
      end
    end

    // Request detection and protocol-error conditions
    always_comb begin
      accept = (state_q == StPend) & evt_ready[i];
      fall   = req_p_q & ~req_s;
      if (MODE == 0) begin
        det     = req_s & ~ack_q;
        err_set = (state_q == StPend) & fall;
      end else begin
        det     = req_s ^ req_p_q;
        err_set = (state_q != StIdle) & det;
      end
    end

    // State register and flopped outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        state_q <= StIdle;
        ack_q   <= 1'b0;
        err_q   <= 1'b0;
        skip_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        ack_q   <= ack_d;
        err_q   <= err_d;
        skip_q  <= skip_d;
      end
    end

    // Next-state logic
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        StIdle: if (det) state_d = StPend;
        StPend: begin
          if (accept) begin
            // A level request that vanished while pending is delivered but never acked.
            if ((MODE == 0) && (skip_q || fall)) state_d = StIdle;
            else                                 state_d = StAck;
          end
        end
        StAck: if ((MODE != 0) || !req_s) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    // Output decode and next values of the flopped outputs
    always_comb begin
      valid_c = (state_q == StPend);
      busy_c  = (state_q != StIdle);
      err_d   = err_set | (err_q & ~err_clr[i]);
      skip_d  = (state_q == StPend) & (skip_q | err_set);
      if (MODE == 0) ack_d = (state_d == StAck);
      else           ack_d = (state_q == StAck) ? req_s : ack_q;
    end

    assign evt_valid[i] = valid_c;
    assign busy[i]      = busy_c;
    assign ack_async[i] = ack_q;
    assign err[i]       = err_q;

`ifdef HS_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating accepted-event counter; clear beats a coincident increment
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr[i])                              cnt_d = '0;
      else if (accept && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    // Counter register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end

    assign evt_cnt[i*CNT_W +: CNT_W] = cnt_q;
`else
    assign evt_cnt[i*CNT_W +: CNT_W] = '0;
`endif
  end

`ifndef HS_CNT_EN
  logic unused_cnt_clr;
  assign unused_cnt_clr = ^cnt_clr;
`endif

endmodule

// File: tb/tb_handshake_sync_rx_mc.sv
// Bench for handshake_sync_rx_mc: one MODE 0 instance (CNT_W=2) and one MODE 1 instance.
`timescale 1ns/1ps
module tb_handshake_sync_rx_mc;
  localparam int Cw0 = 2;
  localparam int Cw1 = 8;

  logic sys_clk;
  logic sys_rst;
  logic [3:0] req0, ack0, val0, rdy0, busy0, err0, eclr0, cclr0;
  logic [3:0] req1, ack1, val1, rdy1, busy1, err1, eclr1, cclr1;
  logic [4*Cw0-1:0] cnt0;
  logic [4*Cw1-1:0] cnt1;
  int checks;
  int errors;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  handshake_sync_rx_mc #(.CH(4), .SYNC_STAGES(2), .MODE(0), .CNT_W(Cw0)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req_async(req0), .ack_async(ack0),
    .evt_valid(val0), .evt_ready(rdy0), .busy(busy0), .err(err0), .err_clr(eclr0),
    .cnt_clr(cclr0), .evt_cnt(cnt0)
  );

  handshake_sync_rx_mc #(.CH(4), .SYNC_STAGES(2), .MODE(1), .CNT_W(Cw1)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req_async(req1), .ack_async(ack1),
    .evt_valid(val1), .evt_ready(rdy1), .busy(busy1), .err(err1), .err_clr(eclr1),
    .cnt_clr(cclr1), .evt_cnt(cnt1)
  );

  // Expected counter value after n accepted events on a w-bit counter.
  function automatic int exp_cnt(input int n, input int w);
`ifdef HS_CNT_EN
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
`else
    return 0 * (n + w);
`endif
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    req0 = '0; rdy0 = '0; eclr0 = '0; cclr0 = '0;
    req1 = '0; rdy1 = '0; eclr1 = '0; cclr1 = '0;
    #3;
    checks++; if ({ack0, val0, busy0, err0} !== 16'h0) begin errors++;
      $display("FAIL reset_flags0 got %h want 0000", {ack0, val0, busy0, err0}); end
    checks++; if ({ack1, val1, busy1, err1} !== 16'h0) begin errors++;
      $display("FAIL reset_flags1 got %h want 0000", {ack1, val1, busy1, err1}); end
    checks++; if (cnt0 !== '0) begin errors++; $display("FAIL reset_cnt0 got %h want 0", cnt0); end
    checks++; if (cnt1 !== '0) begin errors++; $display("FAIL reset_cnt1 got %h want 0", cnt1); end
    tick(); tick();
    sys_rst = 1'b0;
    tick(); tick();
    checks++; if ({ack0, val0, busy0, err0, ack1, val1, busy1, err1} !== 32'h0) begin errors++;
      $display("FAIL post_reset_idle got %h want 0", {ack0, val0, busy0, err0, ack1, val1,
               busy1, err1}); end
  endtask

  task automatic test_m0_pulse();
    int ev;
    ev = 0;
    rdy0 = 4'hF;
    req0[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (val0[0] & rdy0[0]) ev++;
      tick();
      checks++; if (val0[0] !== 1'(k == 3)) begin errors++;
        $display("FAIL m0_valid_lat cyc %0d got %b want %b", k, val0[0], k == 3); end
      checks++; if (ack0[0] !== 1'(k == 4)) begin errors++;
        $display("FAIL m0_ack_rise cyc %0d got %b want %b", k, ack0[0], k == 4); end
    end
    repeat (16) begin
      if (val0[0] & rdy0[0]) ev++;
      tick();
    end
    checks++; if ({ack0[0], busy0[0]} !== 2'b11) begin errors++;
      $display("FAIL m0_ack_hold got %b want 11", {ack0[0], busy0[0]}); end
    req0[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (ack0[0] !== 1'(k < 3)) begin errors++;
        $display("FAIL m0_ack_fall cyc %0d got %b want %b", k, ack0[0], k < 3); end
    end
    checks++; if (ev != 1) begin errors++; $display("FAIL m0_event_count got %0d want 1", ev); end
    checks++; if (err0[0] !== 1'b0) begin errors++; $display("FAIL m0_err got %b want 0", err0[0]);
    end
  endtask

  task automatic test_m0_backpressure();
    int ev;
    ev = 0;
    rdy0[1] = 1'b0;
    req0[1] = 1'b1;
    repeat (3) tick();
    checks++; if (val0[1] !== 1'b1) begin errors++;
      $display("FAIL bp_valid_rise got %b want 1", val0[1]); end
    for (int k = 0; k < 10; k++) begin
      if (val0[1] & rdy0[1]) ev++;
      tick();
      checks++; if ({val0[1], ack0[1]} !== 2'b10) begin errors++;
        $display("FAIL bp_hold cyc %0d valid/ack got %b want 10", k, {val0[1], ack0[1]}); end
    end
    rdy0[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (val0[1] & rdy0[1]) ev++;
      tick();
    end
    checks++; if ({val0[1], ack0[1]} !== 2'b01) begin errors++;
      $display("FAIL bp_accept valid/ack got %b want 01", {val0[1], ack0[1]}); end
    checks++; if (ev != 1) begin errors++; $display("FAIL bp_event_count got %0d want 1", ev); end
    req0[1] = 1'b0;
    repeat (3) tick();
    checks++; if (ack0[1] !== 1'b0) begin errors++; $display("FAIL bp_ack_drop got %b want 0",
      ack0[1]); end
  endtask

  task automatic test_m1_toggle();
    int ev;
    int guard;
    ev = 0;
    rdy1 = 4'hF;
    for (int t = 0; t < 3; t++) begin
      req1[2] = ~req1[2];
      guard = 0;
      while (!(ack1[2] === req1[2] && busy1[2] === 1'b0) && guard < 20) begin
        if (val1[2] & rdy1[2]) ev++;
        tick();
        guard++;
        if (t == 0 && guard == 3) begin
          checks++; if (val1[2] !== 1'b1) begin errors++;
            $display("FAIL m1_valid_lat got %b want 1", val1[2]); end
        end
      end
      checks++; if (guard >= 20) begin errors++;
        $display("FAIL m1_toggle_timeout toggle %0d ack %b req %b", t, ack1[2], req1[2]); end
    end
    checks++; if (ev != 3) begin errors++; $display("FAIL m1_event_count got %0d want 3", ev); end
    checks++; if (ack1[2] !== 1'b1) begin errors++; $display("FAIL m1_ack_level got %b want 1",
      ack1[2]); end
    checks++; if (int'(cnt1[2*Cw1 +: Cw1]) != exp_cnt(3, Cw1)) begin errors++;
      $display("FAIL m1_cnt got %0d want %0d", cnt1[2*Cw1 +: Cw1], exp_cnt(3, Cw1)); end
  endtask

  task automatic test_m1_double();
    int ev;
    int guard;
    ev = 0;
    rdy1[3] = 1'b0;
    req1[3] = 1'b1;
    repeat (3) tick();
    checks++; if (val1[3] !== 1'b1) begin errors++; $display("FAIL dbl_pend got %b want 1",
      val1[3]); end
    req1[3] = 1'b0;
    tick();
    req1[3] = 1'b1;
    repeat (4) tick();
    checks++; if (err1[3] !== 1'b1) begin errors++; $display("FAIL dbl_err_set got %b want 1",
      err1[3]); end
    rdy1[3] = 1'b1;
    guard = 0;
    while (guard < 10) begin
      if (val1[3] & rdy1[3]) ev++;
      tick();
      guard++;
    end
    checks++; if (ev != 1) begin errors++; $display("FAIL dbl_event_count got %0d want 1", ev); end
    checks++; if ({ack1[3], busy1[3]} !== 2'b10) begin errors++;
      $display("FAIL dbl_final ack/busy got %b want 10", {ack1[3], busy1[3]}); end
    eclr1[3] = 1'b1;
    tick();
    eclr1[3] = 1'b0;
    checks++; if (err1[3] !== 1'b0) begin errors++; $display("FAIL dbl_err_clr got %b want 0",
      err1[3]); end
  endtask

  // One complete 4-phase handshake on MODE 0 channel 0 with ready held high.
  task automatic m0_handshake_ch0(input int idx);
    int guard;
    rdy0[0] = 1'b1;
    req0[0] = 1'b1;
    guard = 0;
    while (ack0[0] !== 1'b1 && guard < 20) begin tick(); guard++; end
    checks++; if (guard >= 20) begin errors++; $display("FAIL cnt_hs_ack_rise %0d timeout", idx);
    end
    req0[0] = 1'b0;
    guard = 0;
    while (ack0[0] !== 1'b0 && guard < 20) begin tick(); guard++; end
    checks++; if (guard >= 20) begin errors++; $display("FAIL cnt_hs_ack_fall %0d timeout", idx);
    end
  endtask

  task automatic test_counter();
    int guard;
    cclr0 = 4'hF;
    tick();
    cclr0 = 4'h0;
    for (int n = 1; n <= 5; n++) begin
      m0_handshake_ch0(n);
      checks++; if (int'(cnt0[0 +: Cw0]) != exp_cnt(n, Cw0)) begin errors++;
        $display("FAIL cnt_after_%0d got %0d want %0d", n, cnt0[0 +: Cw0], exp_cnt(n, Cw0)); end
    end
    // Clear coinciding with an acceptance must leave zero.
    rdy0[0] = 1'b0;
    req0[0] = 1'b1;
    guard = 0;
    while (val0[0] !== 1'b1 && guard < 20) begin tick(); guard++; end
    checks++; if (guard >= 20) begin errors++; $display("FAIL cnt_coinc_valid timeout"); end
    rdy0[0] = 1'b1;
    cclr0[0] = 1'b1;
    tick();
    cclr0[0] = 1'b0;
    checks++; if (cnt0[0 +: Cw0] !== '0) begin errors++;
      $display("FAIL cnt_clr_vs_inc got %0d want 0", cnt0[0 +: Cw0]); end
    req0[0] = 1'b0;
    repeat (5) tick();
    m0_handshake_ch0(6);
    checks++; if (int'(cnt0[0 +: Cw0]) != exp_cnt(1, Cw0)) begin errors++;
      $display("FAIL cnt_restart got %0d want %0d", cnt0[0 +: Cw0], exp_cnt(1, Cw0)); end
    cclr0[0] = 1'b1;
    tick();
    cclr0[0] = 1'b0;
    checks++; if (cnt0[0 +: Cw0] !== '0) begin errors++;
      $display("FAIL cnt_clr got %0d want 0", cnt0[0 +: Cw0]); end
  endtask

  task automatic test_all_channels();
    int evc[4];
    rdy0 = 4'hF;
    req0 = 4'hF;
    repeat (3) tick();
    checks++; if (val0 !== 4'hF) begin errors++; $display("FAIL all_valid got %h want f", val0);
    end
    tick();
    checks++; if ({ack0, val0} !== 8'hF0) begin errors++;
      $display("FAIL all_ack ack/valid got %h want f0", {ack0, val0}); end
    req0 = 4'h0;
    repeat (3) tick();
    checks++; if (ack0 !== 4'h0) begin errors++; $display("FAIL all_ack_drop got %h want 0", ack0);
    end
    rdy0 = 4'h0;
    req0 = 4'hF;
    repeat (3) tick();
    checks++; if ({val0, busy0} !== 8'hFF) begin errors++;
      $display("FAIL all_pend valid/busy got %h want ff", {val0, busy0}); end
    // Asynchronous reset in the middle of the cycle.
    #2;
    sys_rst = 1'b1;
    req1 = 4'hF;
    #1;
    checks++; if ({ack0, val0, busy0, err0, ack1, val1, busy1, err1} !== 32'h0) begin errors++;
      $display("FAIL async_reset got %h want 0", {ack0, val0, busy0, err0, ack1, val1, busy1,
               err1}); end
    checks++; if ({cnt0, cnt1} !== '0) begin errors++;
      $display("FAIL async_reset_cnt got %h want 0", {cnt0, cnt1}); end
    req0 = 4'h0;
    rdy1 = 4'hF;
    tick();
    sys_rst = 1'b0;
    for (int c = 0; c < 4; c++) evc[c] = 0;
    repeat (10) begin
      for (int c = 0; c < 4; c++) if (val1[c] & rdy1[c]) evc[c]++;
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      checks++; if (evc[c] != 1) begin errors++;
        $display("FAIL held_req_event ch %0d got %0d want 1", c, evc[c]); end
    end
    checks++; if ({ack1, val0, busy0} !== 12'hF00) begin errors++;
      $display("FAIL post_reset_state got %h want f00", {ack1, val0, busy0}); end
  endtask

  task automatic test_random();
    int iss0[4], iss1[4], acc0[4], acc1[4];
    bit pv0[4], pr0[4], pv1[4], pr1[4];
    int viol;
    int guard;
    viol = 0;
    for (int c = 0; c < 4; c++) begin
      iss0[c] = 0; iss1[c] = 0; acc0[c] = 0; acc1[c] = 0;
      pv0[c] = 0; pr0[c] = 0; pv1[c] = 0; pr1[c] = 0;
    end
    cclr0 = 4'hF; cclr1 = 4'hF; eclr0 = 4'hF; eclr1 = 4'hF;
    tick();
    cclr0 = 4'h0; cclr1 = 4'h0; eclr0 = 4'h0; eclr1 = 4'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        if (!req0[c] && !ack0[c] && $urandom_range(0, 3) == 0) begin
          req0[c] = 1'b1; iss0[c]++;
        end else if (req0[c] && ack0[c] && $urandom_range(0, 2) == 0) begin
          req0[c] = 1'b0;
        end
        if (req1[c] == ack1[c] && $urandom_range(0, 3) == 0) begin
          req1[c] = ~req1[c]; iss1[c]++;
        end
        if (pv0[c] && !pr0[c] && !val0[c]) viol++;
        if (pv1[c] && !pr1[c] && !val1[c]) viol++;
        rdy0[c] = ($urandom_range(0, 3) != 0);
        rdy1[c] = ($urandom_range(0, 3) != 0);
        if (val0[c] & rdy0[c]) acc0[c]++;
        if (val1[c] & rdy1[c]) acc1[c]++;
        pv0[c] = val0[c]; pr0[c] = rdy0[c]; pv1[c] = val1[c]; pr1[c] = rdy1[c];
      end
      tick();
    end
    rdy0 = 4'hF;
    rdy1 = 4'hF;
    guard = 0;
    while (!(busy0 == 4'h0 && busy1 == 4'h0 && req0 == 4'h0 && ack0 == 4'h0 && ack1 == req1)
           && guard < 400) begin
      for (int c = 0; c < 4; c++) begin
        if (req0[c] && ack0[c]) req0[c] = 1'b0;
        if (pv0[c] && !pr0[c] && !val0[c]) viol++;
        if (pv1[c] && !pr1[c] && !val1[c]) viol++;
        if (val0[c]) acc0[c]++;
        if (val1[c]) acc1[c]++;
        pv0[c] = val0[c]; pr0[c] = 1'b1; pv1[c] = val1[c]; pr1[c] = 1'b1;
      end
      tick();
      guard++;
    end
    checks++; if (guard >= 400) begin errors++;
      $display("FAIL rnd_drain timeout busy0 %h busy1 %h", busy0, busy1); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (acc0[c] != iss0[c]) begin errors++;
        $display("FAIL rnd_m0_events ch %0d got %0d want %0d", c, acc0[c], iss0[c]); end
      checks++; if (acc1[c] != iss1[c]) begin errors++;
        $display("FAIL rnd_m1_events ch %0d got %0d want %0d", c, acc1[c], iss1[c]); end
      checks++; if (int'(cnt0[c*Cw0 +: Cw0]) != exp_cnt(iss0[c], Cw0)) begin errors++;
        $display("FAIL rnd_m0_cnt ch %0d got %0d want %0d", c, cnt0[c*Cw0 +: Cw0],
                 exp_cnt(iss0[c], Cw0)); end
      checks++; if (int'(cnt1[c*Cw1 +: Cw1]) != exp_cnt(iss1[c], Cw1)) begin errors++;
        $display("FAIL rnd_m1_cnt ch %0d got %0d want %0d", c, cnt1[c*Cw1 +: Cw1],
                 exp_cnt(iss1[c], Cw1)); end
    end
    checks++; if ({err0, err1} !== 8'h0) begin errors++;
      $display("FAIL rnd_err got %h want 00", {err0, err1}); end
    checks++; if (viol != 0) begin errors++;
      $display("FAIL rnd_valid_drop got %0d want 0", viol); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_m0_pulse();
    test_m0_backpressure();
    test_m1_toggle();
    test_m1_double();
    test_counter();
    test_all_channels();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
